// File: rtl/framebuffer_swap_clear.sv
// Double-buffer controller: forwards render writes into the back buffer, swaps on
// display frame start, optionally clears the new back buffer (macro SWAP_CLEAR_EN).
module framebuffer_swap_clear #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int ADDR_WIDTH  = 18,
  parameter int PIXEL_WIDTH = 3
) (
  input  logic                   aClock,
  input  logic                   aReset,
  input  logic                   aFrameDone,
  input  logic                   aFrameStart,
  input  logic [PIXEL_WIDTH-1:0] aClearColor,
  input  logic [ADDR_WIDTH-1:0]  aRenderAddr,
  input  logic [PIXEL_WIDTH-1:0] aRenderData,
  input  logic                   aRenderWrite,
  output logic [ADDR_WIDTH-1:0]  anOutWriteAddr,
  output logic [PIXEL_WIDTH-1:0] anOutWriteData,
  output logic                   anOutWriteEnable,
  output logic [ADDR_WIDTH-1:0]  anOutReadBase,
  output logic                   anOutFrameFlipped,
  output logic                   anOutBusy
);

  localparam logic [ADDR_WIDTH-1:0] FRAME_SIZE = ADDR_WIDTH'(WIDTH * HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX   = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    RENDER     = 2'd0,
    WAIT_START = 2'd1,
    CLEAR      = 2'd2,
    RELEASE    = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   select_q;
  logic                   done_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;
  logic [PIXEL_WIDTH-1:0] wdata_q;
  logic                   wen_q;
  logic [ADDR_WIDTH-1:0]  rbase_q;
  logic                   flip_q;
  logic                   busy_q;

  logic [ADDR_WIDTH-1:0]  back_base;
  logic                   render_ok;
  logic                   done_rise;

  // The back base before a swap is the front base after it.
  assign back_base = select_q ? '0 : FRAME_SIZE;
  assign render_ok = aRenderWrite && (aRenderAddr < FRAME_SIZE);
  assign done_rise = aFrameDone && !done_q;

`ifdef SWAP_CLEAR_EN
  logic [ADDR_WIDTH-1:0] count_q;
`else
  logic unused_clear_color;
  assign unused_clear_color = ^aClearColor;
`endif

  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
`ifdef SWAP_CLEAR_EN
      state_q <= CLEAR;
      count_q <= '0;
`else
      state_q <= RELEASE;
`endif
      select_q <= 1'b0;
      done_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      rbase_q  <= '0;
      flip_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      done_q <= aFrameDone;
      wen_q  <= 1'b0;
      flip_q <= 1'b0;
      case (state_q)
        RENDER: begin
          if (render_ok) begin
            wen_q   <= 1'b1;
            waddr_q <= back_base + aRenderAddr;
            wdata_q <= aRenderData;
          end
          if (done_rise) begin
            state_q <= WAIT_START;
            busy_q  <= 1'b1;
          end
        end
        WAIT_START: begin
          if (aFrameStart) begin
            select_q <= ~select_q;
            rbase_q  <= back_base;
`ifdef SWAP_CLEAR_EN
            count_q  <= '0;
            state_q  <= CLEAR;
`else
            state_q  <= RELEASE;
`endif
          end
        end
`ifdef SWAP_CLEAR_EN
        CLEAR: begin
          wen_q   <= 1'b1;
          waddr_q <= back_base + count_q;
          wdata_q <= aClearColor;
          count_q <= count_q + ADDR_WIDTH'(1);
          if (count_q == LAST_PIX) begin
            state_q <= RELEASE;
          end
        end
`endif
        RELEASE: begin
          flip_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= RENDER;
        end
        default: begin
          state_q <= RENDER;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign anOutWriteAddr    = waddr_q;
  assign anOutWriteData    = wdata_q;
  assign anOutWriteEnable  = wen_q;
  assign anOutReadBase     = rbase_q;
  assign anOutFrameFlipped = flip_q;
  assign anOutBusy         = busy_q;

endmodule

// File: tb/tb_framebuffer_swap_clear.sv
// Directed bench for framebuffer_swap_clear with a 4x2 frame; expectations follow
// the SWAP_CLEAR_EN macro (clear sequence when defined, direct flip otherwise).
module tb_framebuffer_swap_clear;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FS = W * H;
  localparam int AW = 18;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          done, fstart, rwrite;
  logic [PW-1:0] ccolor, rdata;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr, rbase;
  logic [PW-1:0] wdata;
  logic          wen, flip, busy;

  int n_total = 0;
  int n_bad   = 0;
  int wen_seen = 0;

  always #5 clk = ~clk;

  framebuffer_swap_clear #(
    .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)
  ) dut (
    .aClock(clk), .aReset(rst_n), .aFrameDone(done), .aFrameStart(fstart),
    .aClearColor(ccolor), .aRenderAddr(raddr), .aRenderData(rdata),
    .aRenderWrite(rwrite), .anOutWriteAddr(waddr), .anOutWriteData(wdata),
    .anOutWriteEnable(wen), .anOutReadBase(rbase),
    .anOutFrameFlipped(flip), .anOutBusy(busy)
  );

  always @(posedge clk) if (wen) wen_seen++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".wen"},   32'(wen),   32'd0);
    check({tag, ".waddr"}, 32'(waddr), 32'd0);
    check({tag, ".wdata"}, 32'(wdata), 32'd0);
    check({tag, ".flip"},  32'(flip),  32'd0);
    check({tag, ".busy"},  32'(busy),  32'd1);
    check({tag, ".rbase"}, 32'(rbase), 32'd0);
  endtask

  // Flip pulse with busy dropping, then flip clears on the following cycle.
  task automatic expect_flip(input int exp_rbase);
    tick;
    check("flip.pulse", 32'(flip), 32'd1);
    check("flip.busy",  32'(busy), 32'd0);
    check("flip.wen",   32'(wen),  32'd0);
    check("flip.rbase", 32'(rbase), 32'(exp_rbase));
    tick;
    check("flip.once",  32'(flip), 32'd0);
  endtask

  task automatic expect_clear(input int base, input int nwrites);
    for (int k = 0; k < nwrites; k++) begin
      ccolor = PW'(k + 3);
      tick;
      check("clr.wen",  32'(wen),   32'd1);
      check("clr.addr", 32'(waddr), 32'(base + k));
      check("clr.data", 32'(wdata), 32'((k + 3) % 8));
      check("clr.busy", 32'(busy),  32'd1);
      check("clr.flip", 32'(flip),  32'd0);
    end
    ccolor = 3'd5;
  endtask

  // Rising aFrameDone with a simultaneous write, a wait with dropped writes, then the swap.
  task automatic swap(input int exp_rbase, input int wait_cycles);
    done = 1'b0;
    tick;
    done = 1'b1; rwrite = 1'b1; raddr = 18'd1; rdata = 3'd2;
    tick;
    check("edge.wen",  32'(wen),   32'd1);
    check("edge.addr", 32'(waddr), 32'(exp_rbase + 1));
    check("edge.busy", 32'(busy),  32'd1);
    raddr = 18'd2;
    for (int i = 0; i < wait_cycles; i++) begin
      tick;
      check("wait.wen",   32'(wen),   32'd0);
      check("wait.rbase", 32'(rbase), 32'(exp_rbase == 0 ? FS : 0));
    end
    rwrite = 1'b0;
    fstart = 1'b1;
    tick;
    fstart = 1'b0;
    check("swap.rbase", 32'(rbase), 32'(exp_rbase));
    check("swap.busy",  32'(busy),  32'd1);
    check("swap.flip",  32'(flip),  32'd0);
`ifdef SWAP_CLEAR_EN
    expect_clear(exp_rbase == 0 ? FS : 0, FS);
`endif
    expect_flip(exp_rbase);
  endtask

  initial begin
    rst_n = 1'b0; done = 1'b0; fstart = 1'b0; rwrite = 1'b0;
    ccolor = 3'd5; raddr = '0; rdata = '0;
    repeat (2) tick;
    check_reset_vals("rst");
    rst_n = 1'b1;
`ifdef SWAP_CLEAR_EN
    expect_clear(FS, FS);
`endif
    expect_flip(0);

    rwrite = 1'b1; raddr = 18'd3; rdata = 3'd6;
    tick;
    check("rw.wen",  32'(wen),   32'd1);
    check("rw.addr", 32'(waddr), 32'd11);
    check("rw.data", 32'(wdata), 32'd6);
    raddr = 18'd8;
    tick;
    check("rw.oob", 32'(wen), 32'd0);
    rwrite = 1'b0;
    tick;

    swap(FS, 10);

    for (int i = 0; i < 20; i++) begin
      fstart = (i % 3 == 0);
      tick;
      check("hold.busy",  32'(busy),  32'd0);
      check("hold.flip",  32'(flip),  32'd0);
      check("hold.rbase", 32'(rbase), 32'(FS));
    end
    fstart = 1'b0;

    swap(0, 2);

    done = 1'b0;
    tick;
    done = 1'b1;
    tick;
    done = 1'b0; fstart = 1'b1;
    tick;
    fstart = 1'b0;
    check("mid.rbase", 32'(rbase), 32'(FS));
`ifdef SWAP_CLEAR_EN
    expect_clear(0, 4);
`endif
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    tick;
    rst_n = 1'b1;
`ifdef SWAP_CLEAR_EN
    expect_clear(FS, FS);
`endif
    expect_flip(0);

`ifndef SWAP_CLEAR_EN
    check("noclr.wen_count", 32'(wen_seen), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
